// File: rtl/aes_key_expand_seq_pkg.sv
// Shared AES key-schedule definitions: FSM states, round constant seed,
// GF(2^8) doubling and the forward S-box table.
package aes_key_expand_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Legal key-length / round-count pairs: Nk=4 -> 10, Nk=6 -> 12, Nk=8 -> 14.
  function automatic int roundsForNk(input int nk);
    case (nk)
      4:       return 10;
      6:       return 12;
      8:       return 14;
      default: return 0;
    endcase
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Key-request / round-key bus between a key source and the sequential key expander.
interface aes_key_expand_seq_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic [32*Nk-1:0]      key;
  logic                  key_valid;
  logic                  key_ready;
  logic [128*(Nr+1)-1:0] fullkeys;
  logic                  keys_valid;

  modport master (output key, key_valid, input key_ready, fullkeys, keys_valid);
  modport slave  (input key, key_valid, output key_ready, fullkeys, keys_valid);
endinterface

// File: rtl/aes_key_expand_seq_subword.sv
// SubWord: four parallel S-box substitutions on a 32-bit schedule word.
module aes_key_expand_seq_subword
  import aes_key_expand_seq_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  // Byte-wise substitution, purely combinational.
  always_comb begin
    o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
              sbox(i_word[15:8]),  sbox(i_word[7:0])};
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one 32-bit word per clock through a single
// SubWord instance; round keys are held until the next key is accepted.
module aes_key_expand_seq
  import aes_key_expand_seq_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic clk,
  input  logic reset,
  aes_key_expand_seq_if.slave bus
);

  localparam int NumWords = 4 * (Nr + 1);
  localparam int IW       = $clog2(NumWords);
  localparam logic [IW-1:0] LastIdx = IW'(NumWords - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [31:0]   r_w [NumWords];
  logic [IW-1:0] r_i;
  logic [2:0]    r_kmod;
  logic [7:0]    r_rcon;

  logic                  w_transfer;
  logic [IW-1:0]         w_prevIdx;
  logic [IW-1:0]         w_backIdx;
  logic [31:0]           w_prev;
  logic [31:0]           w_back;
  logic [31:0]           w_subIn;
  logic [31:0]           w_subOut;
  logic [31:0]           w_t;
  logic [31:0]           w_newWord;
  logic [128*(Nr+1)-1:0] w_full;

  assign bus.key_ready  = (r_state != EXPAND);
  assign bus.keys_valid = (r_state == DONE);
  assign w_transfer     = bus.key_valid && (r_state != EXPAND);

  // State register; reset abandons any expansion in flight.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: a key is accepted in IDLE or DONE, EXPAND runs until the last word.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_transfer) w_nextState = EXPAND;
      EXPAND:  if (r_i == LastIdx) w_nextState = DONE;
      DONE:    if (w_transfer) w_nextState = EXPAND;
      default: w_nextState = IDLE;
    endcase
  end

  // Source word addresses w[i-1] and w[i-Nk], clamped when i is below range.
  always_comb begin
    w_prevIdx = '0;
    w_backIdx = '0;
    if (r_i != '0)       w_prevIdx = r_i - IW'(1);
    if (r_i >= IW'(Nk))  w_backIdx = r_i - IW'(Nk);
  end

  assign w_prev  = r_w[w_prevIdx];
  assign w_back  = r_w[w_backIdx];
  assign w_subIn = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_key_expand_seq_subword u_subword (
    .i_word (w_subIn),
    .o_word (w_subOut)
  );

  // Word transform: rotate+sub+rcon at each key-length boundary, extra SubWord mid-way for 256-bit keys.
  always_comb begin
    w_t = w_prev;
    if (r_kmod == 3'd0)                  w_t = w_subOut ^ {r_rcon, 24'h0};
    else if (Nk == 8 && r_kmod == 3'd4)  w_t = w_subOut;
  end

  assign w_newWord = w_back ^ w_t;

  // Schedule storage and counters: load the key on transfer, then write one word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NumWords; k++) r_w[k] <= '0;
      r_i    <= '0;
      r_kmod <= '0;
      r_rcon <= RCON_INIT;
    end else if (w_transfer) begin
      for (int k = 0; k < Nk; k++) r_w[k] <= bus.key[N-1-32*k -: 32];
      r_i    <= IW'(Nk);
      r_kmod <= '0;
      r_rcon <= RCON_INIT;
    end else if (r_state == EXPAND) begin
      r_w[r_i] <= w_newWord;
      if (r_i != LastIdx) r_i <= r_i + IW'(1);
      r_kmod <= (r_kmod == 3'(Nk - 1)) ? 3'd0 : r_kmod + 3'd1;
      if (r_kmod == 3'd0) r_rcon <= xtime(r_rcon);
    end
  end

  // Round key r occupies [r*128 +: 128] with w[4r] in its most significant word.
  always_comb begin
    w_full = '0;
    for (int j = 0; j < NumWords; j++) begin
      w_full[(j/4)*128 + (3-(j%4))*32 +: 32] = r_w[j];
    end
  end

  assign bus.fullkeys = w_full;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: one instance per key length, known-answer
// table, multi-cycle corner sequences and random keys against a reference model.
module tb_aes_key_expand_seq;

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] lastKey;
    int           latency;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [255:0]  keyBus = '0;
  logic [2:0]    kv = '0;
  int            sel = 0;
  logic [1919:0] fullOut;
  logic          kvOut;
  logic          krOut;

  int checks = 0;
  int errors = 0;
  logic [7:0] sboxRef [256];

  always #5 clk = ~clk;

  aes_key_expand_seq_if #(.Nk(4), .Nr(10)) if4 ();
  aes_key_expand_seq_if #(.Nk(6), .Nr(12)) if6 ();
  aes_key_expand_seq_if #(.Nk(8), .Nr(14)) if8 ();

  assign if4.key = keyBus[127:0];
  assign if6.key = keyBus[191:0];
  assign if8.key = keyBus[255:0];
  assign if4.key_valid = kv[0];
  assign if6.key_valid = kv[1];
  assign if8.key_valid = kv[2];

  aes_key_expand_seq #(.N(128), .Nr(10), .Nk(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
  aes_key_expand_seq #(.N(192), .Nr(12), .Nk(6)) u6 (.clk(clk), .reset(reset), .bus(if6));
  aes_key_expand_seq #(.N(256), .Nr(14), .Nk(8)) u8 (.clk(clk), .reset(reset), .bus(if8));

  // Observe the currently selected instance through one zero-extended view.
  always_comb begin
    fullOut = '0;
    kvOut   = 1'b0;
    krOut   = 1'b0;
    case (sel)
      0: begin fullOut[1407:0] = if4.fullkeys; kvOut = if4.keys_valid; krOut = if4.key_ready; end
      1: begin fullOut[1663:0] = if6.fullkeys; kvOut = if6.keys_valid; krOut = if6.key_ready; end
      default: begin fullOut = if8.fullkeys; kvOut = if8.keys_valid; krOut = if8.key_ready; end
    endcase
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWordRef(input logic [31:0] t);
    return {sboxRef[t[31:24]], sboxRef[t[23:16]], sboxRef[t[15:8]], sboxRef[t[7:0]]};
  endfunction

  // FIPS-197 key expansion, packed into the round-key bus layout.
  function automatic logic [1919:0] refFullKeys(input int nk, input logic [255:0] k);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            total;
    total = 4 * (nk + 7);
    rc    = 8'h01;
    res   = '0;
    for (int i = 0; i < nk; i++) w[i] = k[32*nk-1-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWordRef(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < total; j++) res[(j/4)*128 + (3-(j%4))*32 +: 32] = w[j];
    return res;
  endfunction

  function automatic int idxOf(input int nk);
    return (nk == 4) ? 0 : ((nk == 6) ? 1 : 2);
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkFull(input string name, input int nk, input logic [1919:0] exp);
    int bad;
    bad = -1;
    for (int r = nk + 6; r >= 0; r--)
      if (fullOut[r*128 +: 128] !== exp[r*128 +: 128]) bad = r;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s round %0d actual=%h expected=%h", name, bad,
               fullOut[bad*128 +: 128], exp[bad*128 +: 128]);
    end
  endtask

  // Present a key for one cycle and count cycles until keys_valid (transfer cycle counts as 1).
  task automatic applyStimulus(input int nk, input logic [255:0] k, output int lat, output logic fellNext);
    int idx;
    idx = idxOf(nk);
    @(negedge clk);
    sel = idx; keyBus = k; kv[idx] = 1'b1;
    @(posedge clk);
    #1 kv[idx] = 1'b0;
    lat = 1;
    fellNext = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      if (lat == 1) fellNext = ~kvOut;
      if (kvOut) break;
      @(posedge clk);
      lat++;
    end
  endtask

  vec_t vecs [4];
  int   lat;
  logic fell;
  logic readyBad;
  logic [255:0] keyA, keyB, keyC;
  int   nkR;

  initial begin
    vecs[0] = '{4, 256'h2b7e151628aed2a6abf7158809cf4f3c, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 41};
    vecs[1] = '{6, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 128'he98ba06f448c773c8ecc720401002202, 47};
    vecs[2] = '{8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 128'hfe4890d1e6188d0b046df344706c631e, 53};
    vecs[3] = '{4, 256'h000102030405060708090a0b0c0d0e0f, 128'h13111d7fe3944a17f307a78b4d2b30c5, 41};

    buildSbox();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state of each instance.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s;
      #1;
      checkFull("resetFullkeys", 4 + 2*s, '0);
      checkOutput("resetKeysValid", 128'(kvOut), 128'(0));
      checkOutput("resetKeyReady", 128'(krOut), 128'(1));
    end

    // Known-answer table; entry 3 follows entry 0 on the same instance, so it is back-to-back from DONE.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].nk, vecs[v].key, lat, fell);
      checkOutput("katLatency", 128'(lat), 128'(vecs[v].latency));
      checkOutput("katFellNext", 128'(fell), 128'(1));
      checkOutput("katLastRoundKey", fullOut[(vecs[v].nk+6)*128 +: 128], vecs[v].lastKey);
      checkFull("katModel", vecs[v].nk, refFullKeys(vecs[v].nk, vecs[v].key));
    end

    // key_valid pulsed mid-expansion and key changed after transfer: both ignored.
    keyA = vecs[0].key;
    keyB = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    @(negedge clk);
    sel = 0; keyBus = keyA; kv[0] = 1'b1;
    @(posedge clk);
    #1 kv[0] = 1'b0; keyBus = keyB;
    readyBad = 1'b0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (kvOut) break;
      if (krOut) readyBad = 1'b1;
      kv[0] = (lat == 10);
      @(posedge clk);
      lat++;
    end
    kv[0] = 1'b0;
    checkOutput("ignoreReadyLow", 128'(readyBad), 128'(0));
    checkOutput("ignoreLatency", 128'(lat), 128'(41));
    checkOutput("ignoreLastRoundKey", fullOut[1280 +: 128], vecs[0].lastKey);

    // Reset at cycle 20 of an expansion, then a fresh key completes normally.
    @(negedge clk);
    sel = 0; keyBus = keyB; kv[0] = 1'b1;
    @(posedge clk);
    #1 kv[0] = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkFull("midResetFullkeys", 4, '0);
    checkOutput("midResetKeysValid", 128'(kvOut), 128'(0));
    checkOutput("midResetKeyReady", 128'(krOut), 128'(1));
    reset = 1'b1;
    keyC = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(4, keyC, lat, fell);
    checkOutput("afterResetLatency", 128'(lat), 128'(41));
    checkFull("afterResetModel", 4, refFullKeys(4, keyC));

    // Reset and key_valid in the same cycle: reset wins and nothing starts.
    @(negedge clk);
    sel = 0; keyBus = keyA; kv[0] = 1'b1; reset = 1'b0;
    @(negedge clk);
    checkOutput("resetWinsKeysValid", 128'(kvOut), 128'(0));
    checkOutput("resetWinsKeyReady", 128'(krOut), 128'(1));
    kv[0] = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetWinsStillIdle", 128'(krOut), 128'(1));
    checkFull("resetWinsNoLoad", 4, '0);

    // Random keys of random lengths against the reference model.
    for (int r = 0; r < 9; r++) begin
      nkR = 4 + 2 * (r % 3);
      keyC = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(nkR, keyC, lat, fell);
      checkOutput("randLatency", 128'(lat), 128'(4*(nkR+7) - nkR + 1));
      checkFull("randModel", nkR, refFullKeys(nkR, keyC));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
